// File: rtl/rom_fetch_arbiter_pkg.sv
// Shared constants for the ROM fetch arbiter: default geometry, ROM read latency,
// and the index-width helper used to size requester tags.
package rom_fetch_arbiter_pkg;

  localparam int unsigned NREQ_DEF   = 4;
  localparam int unsigned ADDR_W_DEF = 9;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ROM_LAT    = 1;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rom_fetch_arbiter_rr_pick.sv
// Combinational round-robin pick: first eligible requester after the last winner,
// wrapping modulo NREQ.
module rr_pick
  import rom_fetch_arbiter_pkg::*;
#(
  parameter  int unsigned NREQ  = NREQ_DEF,
  localparam int unsigned IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  elig_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             vld_c,
  output logic [IDX_W-1:0] idx_c
);

  int unsigned cand;

  always_comb begin
    vld_c = 1'b0;
    idx_c = '0;
    cand  = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(last_i) + k) % NREQ;
      if (!vld_c && elig_i[cand[IDX_W-1:0]]) begin
        vld_c = 1'b1;
        idx_c = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Shared-ROM fetch arbiter: one registered grant per cycle, read data returned two
// cycles after the grant. Define PF_PRIORITY_EN to give requester 0 priority during active video.
module rom_fetch_arbiter
  import rom_fetch_arbiter_pkg::*;
#(
  parameter int unsigned NREQ   = NREQ_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   display_on,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  output logic [NREQ-1:0]        gnt,
  output logic                   rom_en,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [DATA_W-1:0]      rom_data,
  output logic [DATA_W-1:0]      rdata,
  output logic [NREQ-1:0]        rvalid
);

  localparam int unsigned IDX_W = idx_w(NREQ);

  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              rom_en_q, rom_en_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [IDX_W-1:0]  s0_idx_q, s0_idx_d;
  logic              s1_vld_q, s1_vld_d;
  logic [IDX_W-1:0]  s1_idx_q, s1_idx_d;
  logic [NREQ-1:0]   rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;

  logic [NREQ-1:0]   elig_c;
  logic              rr_vld_c;
  logic [IDX_W-1:0]  rr_idx_c;
  logic              pf_win_c;
  logic              win_c;
  logic [IDX_W-1:0]  win_idx_c;

  // A requester granted this cycle sits out the next arbitration.
  assign elig_c = req & ~gnt_q;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .elig_i (elig_c),
    .last_i (ptr_q),
    .vld_c  (rr_vld_c),
    .idx_c  (rr_idx_c)
  );

`ifdef PF_PRIORITY_EN
  assign pf_win_c = display_on & elig_c[0];
`else
  logic unused_display;
  assign unused_display = display_on;
  assign pf_win_c       = 1'b0;
`endif

  assign win_c     = pf_win_c | rr_vld_c;
  assign win_idx_c = pf_win_c ? '0 : rr_idx_c;

  // Grant stage, ROM-wait stage and return stage each carry a valid plus index tag.
  always_comb begin
    gnt_d      = '0;
    rom_en_d   = win_c;
    rom_addr_d = rom_addr_q;
    s0_idx_d   = s0_idx_q;
    ptr_d      = ptr_q;
    s1_vld_d   = rom_en_q;
    s1_idx_d   = rom_en_q ? s0_idx_q : s1_idx_q;
    rvalid_d   = '0;
    rdata_d    = rdata_q;
    if (win_c) begin
      gnt_d[win_idx_c] = 1'b1;
      rom_addr_d       = req_addr[32'(win_idx_c)*ADDR_W +: ADDR_W];
      s0_idx_d         = win_idx_c;
      // Priority wins by requester 0 leave the rotation untouched.
      if (!pf_win_c) ptr_d = win_idx_c;
    end
    if (s1_vld_q) begin
      rvalid_d[s1_idx_q] = 1'b1;
      rdata_d            = rom_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q      <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      s0_idx_q   <= '0;
      s1_vld_q   <= 1'b0;
      s1_idx_q   <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      ptr_q      <= IDX_W'(NREQ - 1);
    end else begin
      gnt_q      <= gnt_d;
      rom_en_q   <= rom_en_d;
      rom_addr_q <= rom_addr_d;
      s0_idx_q   <= s0_idx_d;
      s1_vld_q   <= s1_vld_d;
      s1_idx_q   <= s1_idx_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      ptr_q      <= ptr_d;
    end
  end

  assign gnt      = gnt_q;
  assign rom_en   = rom_en_q;
  assign rom_addr = rom_addr_q;
  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Scoreboard bench for rom_fetch_arbiter: a cycle-level arbitration model predicts grants
// and returns; a negedge monitor pops and compares whenever the DUT presents them.
module tb_rom_fetch_arbiter;

  localparam int NREQ   = 4;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;
  localparam int AW_ALL = NREQ * ADDR_W;

  typedef struct {
    int cyc;
    int idx;
    int val;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                display_on = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [AW_ALL-1:0]   req_addr = '0;
  logic [NREQ-1:0]     gnt;
  logic                rom_en;
  logic [ADDR_W-1:0]   rom_addr;
  logic [DATA_W-1:0]   rom_data = '0;
  logic [DATA_W-1:0]   rdata;
  logic [NREQ-1:0]     rvalid;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t gq[$];
  exp_t rtq[$];
  int   glog[$];
  bit   rst_at[int];
  int   m_ptr = NREQ - 1;
  int   m_prev = -1;
  int   m_addr = 0;
  int   m_rdata = 0;

  rom_fetch_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .display_on (display_on),
    .req        (req),
    .req_addr   (req_addr),
    .gnt        (gnt),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rdata      (rdata),
    .rvalid     (rvalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rom_f(input int a);
    if (a == 'h012) return 'hA5;
    return ((a * 29) + (a >> 8) + 'h3C) & 'hFF;
  endfunction

  function automatic logic [AW_ALL-1:0] mk_addr(input int a0, input int a1, input int a2, input int a3);
    return {ADDR_W'(a3), ADDR_W'(a2), ADDR_W'(a1), ADDR_W'(a0)};
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Synchronous ROM: data for the address enabled in one cycle appears in the next.
  initial begin : rom_model
    logic            en_s;
    logic [ADDR_W-1:0] a_s;
    forever begin
      @(negedge clk);
      en_s = rom_en;
      a_s  = rom_addr;
      @(posedge clk);
      #1;
      if (en_s === 1'b1) rom_data = DATA_W'(rom_f(int'(a_s)));
    end
  end

  // Reference model: one stimulus cycle -> expected grant next cycle, return two later.
  task automatic step(input bit r, input logic [NREQ-1:0] rq, input logic [AW_ALL-1:0] ad, input bit disp);
    logic [NREQ-1:0] el;
    int w;
    bit pf;
    int a;
    @(posedge clk);
    #1;
    reset = r;
    req = rq;
    req_addr = ad;
    display_on = disp;
    if (r) begin
      m_ptr = NREQ - 1;
      m_prev = -1;
      rst_at[cyc] = 1'b1;
      for (int j = rtq.size() - 1; j >= 0; j--)
        if (rtq[j].cyc > cyc) rtq.delete(j);
    end else begin
      el = rq;
      if (m_prev >= 0) el[m_prev] = 1'b0;
      w = -1;
      pf = 1'b0;
`ifdef PF_PRIORITY_EN
      if (disp && el[0]) begin
        w = 0;
        pf = 1'b1;
      end
`endif
      if (w < 0) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (w < 0 && el[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        end
      end
      if (w >= 0) begin
        if (!pf) m_ptr = w;
        a = int'(ad[w*ADDR_W +: ADDR_W]);
        gq.push_back('{cyc + 1, w, a});
        rtq.push_back('{cyc + 3, w, rom_f(a)});
      end
      m_prev = w;
    end
  endtask

  task automatic check_order(input string nm, input int n, input int ex[8]);
    check({nm, "_count"}, glog.size(), n);
    for (int i = 0; i < n; i++) check(nm, (i < glog.size()) ? glog[i] : -1, ex[i]);
  endtask

  // Monitor: compare on every DUT presentation; flag outputs the model never predicted.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (cyc >= 2) begin
        if (rst_at.exists(cyc - 1)) begin
          m_addr = 0;
          m_rdata = 0;
        end
        if (gnt != '0 || rom_en) begin
          for (int i = 0; i < NREQ; i++) if (gnt[i]) glog.push_back(i);
          if (gq.size() == 0) begin
            check("gnt_unexpected", int'(gnt), 0);
          end else begin
            e = gq.pop_front();
            check("gnt_cycle", cyc, e.cyc);
            check("gnt", int'(gnt), 1 << e.idx);
            check("rom_en", int'(rom_en), 1);
            check("rom_addr", int'(rom_addr), e.val);
            m_addr = e.val;
          end
        end else begin
          check("rom_addr_hold", int'(rom_addr), m_addr);
          if (gq.size() > 0 && gq[0].cyc <= cyc) begin
            e = gq.pop_front();
            check("gnt_missing", int'(gnt), 1 << e.idx);
          end
        end
        if (rvalid != '0) begin
          if (rtq.size() == 0) begin
            check("rvalid_unexpected", int'(rvalid), 0);
          end else begin
            e = rtq.pop_front();
            check("rvalid_cycle", cyc, e.cyc);
            check("rvalid", int'(rvalid), 1 << e.idx);
            check("rdata", int'(rdata), e.val);
            m_rdata = e.val;
          end
        end else begin
          check("rdata_hold", int'(rdata), m_rdata);
          if (rtq.size() > 0 && rtq[0].cyc <= cyc) begin
            e = rtq.pop_front();
            check("rvalid_missing", int'(rvalid), 1 << e.idx);
          end
        end
      end
    end
  end

  initial begin : stim
    int ex[8];
    logic [AW_ALL-1:0] ad;
    ad = mk_addr('h012, 'h034, 'h156, 'h1F8);

    // Single fetch straight out of reset.
    repeat (3) step(1'b1, '0, '0, 1'b0);
    step(1'b0, 4'b0001, ad, 1'b0);
    repeat (4) step(1'b0, '0, ad, 1'b0);

    // All four requesting: plain rotation, no skips.
    step(1'b1, '0, '0, 1'b0);
    glog.delete();
    repeat (8) step(1'b0, 4'b1111, ad, 1'b0);
    repeat (3) step(1'b0, '0, ad, 1'b0);
    ex = '{0, 1, 2, 3, 0, 1, 2, 3};
    check_order("order_all4", 8, ex);

    // Three requesters during active video.
    step(1'b1, '0, '0, 1'b0);
    glog.delete();
    repeat (6) step(1'b0, 4'b0111, ad, 1'b1);
    repeat (3) step(1'b0, '0, ad, 1'b1);
`ifdef PF_PRIORITY_EN
    ex = '{0, 1, 0, 2, 0, 1, -1, -1};
`else
    ex = '{0, 1, 2, 0, 1, 2, -1, -1};
`endif
    check_order("order_disp_on", 6, ex);

    // Same requesters outside active video: rotation in every build.
    step(1'b1, '0, '0, 1'b0);
    glog.delete();
    repeat (6) step(1'b0, 4'b0111, ad, 1'b0);
    repeat (3) step(1'b0, '0, ad, 1'b0);
    ex = '{0, 1, 2, 0, 1, 2, -1, -1};
    check_order("order_disp_off", 6, ex);

    // Requester 3 pulses for one cycle while 0 wins: it must never be served.
    step(1'b1, '0, '0, 1'b0);
    glog.delete();
    step(1'b0, 4'b1001, ad, 1'b0);
    repeat (4) step(1'b0, '0, ad, 1'b0);
    ex = '{0, -1, -1, -1, -1, -1, -1, -1};
    check_order("pulse_dropped", 1, ex);

    // Pointer wrap 3 -> 0 with requesters 0 and 3 held.
    glog.delete();
    repeat (4) step(1'b0, 4'b1001, ad, 1'b0);
    repeat (3) step(1'b0, '0, ad, 1'b0);
    ex = '{3, 0, 3, 0, -1, -1, -1, -1};
    check_order("wrap", 4, ex);

    // Reset right after a grant to requester 2 discards its return.
    step(1'b0, 4'b0100, ad, 1'b0);
    step(1'b1, '0, '0, 1'b0);
    repeat (4) step(1'b0, '0, ad, 1'b0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      ad = AW_ALL'({$urandom(), $urandom()});
      step($urandom_range(0, 39) == 0, NREQ'($urandom_range(0, 15)), ad, 1'($urandom_range(0, 1)));
    end
    repeat (6) step(1'b0, '0, ad, 1'b0);

    check("grant_queue_drained", gq.size(), 0);
    check("return_queue_drained", rtq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
